// File: rtl/alu_ctrl_muldiv.sv
// ALU control decode plus an iterative multiply/divide sequencer with HI/LO registers.
// Signed MULT/DIV run on magnitudes; the FIX cycle restores signs and writes HI/LO.
module alu_ctrl_muldiv #(
  parameter int                 WIDTH      = 32,
  parameter int                 ALUOP_W    = 4,
  parameter logic [ALUOP_W-1:0] RTYPE_CODE = 4'b1111
) (
  input  logic               CLK,
  input  logic               Reset_L,
  input  logic [ALUOP_W-1:0] ALUop,
  input  logic [5:0]         FuncCode,
  input  logic               Issue,
  input  logic [WIDTH-1:0]   OpA,
  input  logic [WIDTH-1:0]   OpB,
  output logic [3:0]         ALUCtrl,
  output logic               MDStall,
  output logic               MDBusy,
  output logic               MfSel,
  output logic [WIDTH-1:0]   MfData,
  output logic [WIDTH-1:0]   HI,
  output logic [WIDTH-1:0]   LO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 mul_q, mul_d, neg_q, neg_d, rneg_q, rneg_d, div0_q, div0_d;

  logic                 rtype, is_md, accept, signed_op, sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       add_sum, trial;

  assign rtype     = (ALUop == RTYPE_CODE);
  assign is_md     = rtype && ((FuncCode[5:2] == 4'b0100) || (FuncCode[5:2] == 4'b0110));
  assign accept    = Issue && is_md && (state_q == IDLE);
  assign MDStall   = Issue && is_md && (state_q != IDLE);
  assign MDBusy    = (state_q != IDLE);
  assign MfSel     = accept && (FuncCode == 6'b010000 || FuncCode == 6'b010010);
  assign MfData    = MfSel ? (FuncCode[1] ? lo_q : hi_q) : '0;
  assign HI        = hi_q;
  assign LO        = lo_q;

  // MULT and DIV have funct bit0 clear; their unsigned twins set it.
  assign signed_op = ~FuncCode[0];
  assign sign_a    = signed_op & OpA[WIDTH-1];
  assign sign_b    = signed_op & OpB[WIDTH-1];
  assign mag_a     = sign_a ? -OpA : OpA;
  assign mag_b     = sign_b ? -OpB : OpB;

  // prod_q holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  assign add_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? opb_q : '0)};
  assign trial     = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]} - {1'b0, opb_q};

  always_comb begin
    ALUCtrl = 4'b0000;
    if (!rtype) begin
      ALUCtrl = ALUop[3:0];
    end else begin
      case (FuncCode)
        6'b000000: ALUCtrl = 4'b0011;
        6'b000010: ALUCtrl = 4'b0100;
        6'b000011: ALUCtrl = 4'b1101;
        6'b100000: ALUCtrl = 4'b0010;
        6'b100001: ALUCtrl = 4'b1000;
        6'b100010: ALUCtrl = 4'b0110;
        6'b100011: ALUCtrl = 4'b1001;
        6'b100100: ALUCtrl = 4'b0000;
        6'b100101: ALUCtrl = 4'b0001;
        6'b100110: ALUCtrl = 4'b1010;
        6'b100111: ALUCtrl = 4'b1100;
        6'b101010: ALUCtrl = 4'b0111;
        6'b101011: ALUCtrl = 4'b1011;
        default:   ALUCtrl = 4'b0000;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    opb_d   = opb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_d   = mul_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (FuncCode)
            6'b010001: hi_d = OpA;
            6'b010011: lo_d = OpA;
            6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
              prod_d  = {{WIDTH{1'b0}}, mag_a};
              opb_d   = mag_b;
              cnt_d   = CW'(WIDTH - 1);
              mul_d   = ~FuncCode[1];
              neg_d   = sign_a ^ sign_b;
              rneg_d  = sign_a;
              div0_d  = (OpB == '0);
              state_d = FuncCode[1] ? DIV : MUL;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        prod_d = {add_sum, prod_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      DIV: begin
        if (!trial[WIDTH]) prod_d = {trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        else               prod_d = {prod_q[2*WIDTH-2:0], 1'b0};
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        if (mul_q) begin
          {hi_d, lo_d} = neg_q ? -prod_q : prod_q;
        end else begin
          // Divide by zero leaves the dividend in the remainder; only LO needs forcing.
          lo_d = div0_q ? '1 : (neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0]);
          hi_d = rneg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      opb_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      opb_q   <= opb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mul_q   <= mul_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed bench for alu_ctrl_muldiv: ALU decode sweep, MULT/DIV results and latency,
// stalled MFHI, MTLO, divide-by-zero, signed overflow and mid-operation reset.
module tb_alu_ctrl_muldiv;

  localparam logic [3:0] RT    = 4'b1111;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;

  logic        CLK;
  logic        Reset_L;
  logic [3:0]  ALUop;
  logic [5:0]  FuncCode;
  logic        Issue;
  logic [31:0] OpA, OpB;
  logic [3:0]  ALUCtrl;
  logic        MDStall, MDBusy, MfSel;
  logic [31:0] MfData, HI, LO;

  int total = 0;
  int bad   = 0;

  logic [5:0] fnTab  [13] = '{6'b000000, 6'b000010, 6'b000011, 6'b100000, 6'b100001,
                              6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
                              6'b100111, 6'b101010, 6'b101011};
  logic [3:0] ctlTab [13] = '{4'b0011, 4'b0100, 4'b1101, 4'b0010, 4'b1000,
                              4'b0110, 4'b1001, 4'b0000, 4'b0001, 4'b1010,
                              4'b1100, 4'b0111, 4'b1011};

  alu_ctrl_muldiv #(.WIDTH(32), .ALUOP_W(4), .RTYPE_CODE(4'b1111)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .ALUop(ALUop), .FuncCode(FuncCode), .Issue(Issue),
    .OpA(OpA), .OpB(OpB), .ALUCtrl(ALUCtrl), .MDStall(MDStall), .MDBusy(MDBusy),
    .MfSel(MfSel), .MfData(MfData), .HI(HI), .LO(LO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic [3:0] op, input logic [5:0] fn, input logic iss,
                               input logic [31:0] a, input logic [31:0] b);
    ALUop    = op;
    FuncCode = fn;
    Issue    = iss;
    OpA      = a;
    OpB      = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one mul/div op, then count busy cycles (bounded) and check HI/LO.
  task automatic runOp(input string tag, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi,
                       input logic [31:0] expLo);
    int n;
    applyStimulus(RT, fn, 1'b1, a, b);
    @(negedge CLK);
    applyStimulus(RT, 6'b100000, 1'b0, 32'h0, 32'h0);
    #1;
    n = 0;
    while (MDBusy === 1'b1 && n < 100) begin
      checkOutput({tag, " no stall"}, {31'b0, MDStall}, 32'd0);
      n++;
      @(negedge CLK);
      #1;
    end
    checkOutput({tag, " busy cycles"}, n, 32'd33);
    checkOutput({tag, " HI"}, HI, expHi);
    checkOutput({tag, " LO"}, LO, expLo);
  endtask

  initial begin
    int n;
    Reset_L = 1'b0;
    applyStimulus(4'b0000, 6'b000000, 1'b0, 32'h0, 32'h0);
    #3;
    checkOutput("reset HI", HI, 32'h0);
    checkOutput("reset LO", LO, 32'h0);
    checkOutput("reset MDBusy", {31'b0, MDBusy}, 32'd0);
    @(negedge CLK);
    Reset_L = 1'b1;
    $display("[TB] ALU decode sweep");

    for (int i = 0; i < 13; i++) begin
      applyStimulus(RT, fnTab[i], 1'b0, 32'h0, 32'h0);
      #1;
      checkOutput($sformatf("ALUCtrl funct %b", fnTab[i]), {28'b0, ALUCtrl}, {28'b0, ctlTab[i]});
    end
    applyStimulus(4'b0010, 6'b100010, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("ALUCtrl passthrough 0010", {28'b0, ALUCtrl}, 32'h2);
    applyStimulus(RT, MULT, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("ALUCtrl funct MULT", {28'b0, ALUCtrl}, 32'h0);
    checkOutput("MfSel non-mf", {31'b0, MfSel}, 32'd0);
    @(negedge CLK);

    $display("[TB] multiply and divide");
    runOp("MULT -3*5", MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    runOp("MULTU max*max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    runOp("DIVU 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    runOp("DIV -7/2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("DIV ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    runOp("DIVU 9/0", DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF);

    $display("[TB] MFHI stalled behind MULT");
    applyStimulus(RT, MULT, 1'b1, 32'h00010000, 32'h00030000);
    @(negedge CLK);
    applyStimulus(RT, MFHI, 1'b1, 32'h0, 32'h0);
    #1;
    n = 0;
    while (MDBusy === 1'b1 && n < 100) begin
      checkOutput("mfhi stall", {31'b0, MDStall}, 32'd1);
      checkOutput("mfhi sel while busy", {31'b0, MfSel}, 32'd0);
      n++;
      @(negedge CLK);
      #1;
    end
    checkOutput("mfhi busy cycles", n, 32'd33);
    checkOutput("mfhi MfSel", {31'b0, MfSel}, 32'd1);
    checkOutput("mfhi MfData", MfData, 32'd3);
    checkOutput("mfhi MDStall idle", {31'b0, MDStall}, 32'd0);

    applyStimulus(RT, MTLO, 1'b1, 32'h00001234, 32'h0);
    @(negedge CLK);
    applyStimulus(RT, 6'b100000, 1'b0, 32'h0, 32'h0);
    #1;
    checkOutput("MTLO LO", LO, 32'h00001234);
    checkOutput("MTLO HI kept", HI, 32'd3);
    checkOutput("MTLO not busy", {31'b0, MDBusy}, 32'd0);

    $display("[TB] reset during DIV");
    applyStimulus(RT, DIV, 1'b1, 32'd1000, 32'd3);
    @(negedge CLK);
    applyStimulus(RT, 6'b100000, 1'b0, 32'h0, 32'h0);
    repeat (9) @(negedge CLK);
    #1;
    checkOutput("div busy before reset", {31'b0, MDBusy}, 32'd1);
    Reset_L = 1'b0;
    #1;
    checkOutput("async reset MDBusy", {31'b0, MDBusy}, 32'd0);
    checkOutput("async reset HI", HI, 32'h0);
    checkOutput("async reset LO", LO, 32'h0);
    @(negedge CLK);
    Reset_L = 1'b1;
    @(negedge CLK);
    runOp("MULTU 6*7", MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
